// File: rtl/dice_roller_multi.sv
// Multi-die BCD roller with exponential spin-down and a scanned seven-segment display.
// The die is chosen when a roll starts. The value counts down in BCD while roll is held.
// After release the value takes SETTLE_STEPS more steps, spaced 1, 2, 4, ... clocks apart.
// It then freezes and done pulses for one cycle.
// The display scans one digit per 2^SCAN_DIV clocks and blanks leading zeros.
module dice_roller_multi #(
    parameter int DIGITS           = 3,
    parameter int SETTLE_STEPS     = 4,
    parameter int SCAN_DIV         = 4,
    parameter int BLANK_WHILE_ROLL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  roll,
    input  logic [2:0]            sel,
    input  logic [4*DIGITS-1:0]   custom_max,
    input  logic                  seg_inv,
    input  logic                  dig_inv,
    output logic [4*DIGITS-1:0]   value,
    output logic                  busy,
    output logic                  done,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig
);

    localparam int VW  = 4 * DIGITS;
    localparam int SLW = $clog2(DIGITS);
    localparam logic [VW-1:0]       BCD_ONE   = VW'(4'd1);
    localparam logic [3:0]          LAST_K    = 4'(SETTLE_STEPS - 1);
    localparam logic [SLW-1:0]      LAST_SLOT = SLW'(DIGITS - 1);
    localparam logic [SCAN_DIV-1:0] SCAN_WRAP = {SCAN_DIV{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROLLING = 2'd1,
        ST_SETTLE  = 2'd2,
        ST_SHOW    = 2'd3
    } state_t;

    state_t              state_r;
    logic [VW-1:0]       value_r;
    logic [VW-1:0]       max_r;
    logic                busy_r;
    logic                done_r;
    logic [3:0]          k_r;
    logic [7:0]          timer_r;
    logic [SCAN_DIV-1:0] scan_timer_r;
    logic [SLW-1:0]      slot_r;
    logic [6:0]          seg_r;
    logic [DIGITS-1:0]   dig_r;

    logic [VW-1:0]       max_sel_s;
    logic [VW-1:0]       value_step_s;
    logic [7:0]          settle_limit_s;
    logic [15:0]         value_pad_s;
    logic [3:0]          cur_digit_s;
    logic                zero_run_s;
    logic [DIGITS-1:0]   lead_zero_s;
    logic [DIGITS-1:0]   dig_next_s;

    // BCD decrement by one, borrowing across digits (e.g. 100 -> 099).
    function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // A custom maximum is usable only if it is non-zero and every digit is 0..9.
    function automatic logic custom_ok(input logic [VW-1:0] v);
        logic ok;
        ok = (v != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    // Segment pattern (gfedcba) for one BCD digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Die maximum selected at roll start.
    always_comb begin
        max_sel_s = BCD_ONE;
        case (sel)
            3'd0:    max_sel_s = VW'(12'h004);
            3'd1:    max_sel_s = VW'(12'h006);
            3'd2:    max_sel_s = VW'(12'h008);
            3'd3:    max_sel_s = VW'(12'h010);
            3'd4:    max_sel_s = VW'(12'h012);
            3'd5:    max_sel_s = VW'(12'h020);
            3'd6:    max_sel_s = VW'(12'h100);
            3'd7: begin
                if (custom_ok(custom_max)) begin
                    max_sel_s = custom_max;
                end else begin
                    max_sel_s = BCD_ONE;
                end
            end
            default: max_sel_s = BCD_ONE;
        endcase
    end

    // Next value for one step: wrap from 1 back to the latched maximum, else decrement.
    always_comb begin
        value_step_s   = bcd_dec(value_r);
        settle_limit_s = (8'd1 << k_r) - 8'd1;
        if (value_r == BCD_ONE) begin
            value_step_s = max_r;
        end else begin
            value_step_s = bcd_dec(value_r);
        end
    end

    // Roll control FSM with registered value, busy and done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            value_r <= BCD_ONE;
            max_r   <= BCD_ONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            k_r     <= 4'd0;
            timer_r <= 8'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_SHOW: begin
                    if (roll) begin
                        max_r   <= max_sel_s;
                        value_r <= max_sel_s;
                        state_r <= ST_ROLLING;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_ROLLING: begin
                    if (roll) begin
                        value_r <= value_step_s;
                    end else begin
                        state_r <= ST_SETTLE;
                        k_r     <= 4'd0;
                        timer_r <= 8'd0;
                    end
                end
                ST_SETTLE: begin
                    if (roll) begin
                        state_r <= ST_ROLLING;
                    end else if (timer_r == settle_limit_s) begin
                        value_r <= value_step_s;
                        timer_r <= 8'd0;
                        k_r     <= k_r + 4'd1;
                        if (k_r == LAST_K) begin
                            state_r <= ST_SHOW;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        timer_r <= timer_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Digit under the scan slot, plus the leading-zero map (digit 0 is never blanked).
    always_comb begin
        value_pad_s = 16'(value_r);
        cur_digit_s = value_pad_s[{slot_r, 2'b00} +: 4];
        zero_run_s  = 1'b1;
        lead_zero_s = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run_s     = zero_run_s & (value_r[4*i +: 4] == 4'd0);
            lead_zero_s[i] = zero_run_s;
        end
    end

    // Digit enable for the current slot, dark while busy when blanking is enabled.
    always_comb begin
        dig_next_s = '0;
        if ((BLANK_WHILE_ROLL != 0) && busy_r) begin
            dig_next_s = '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                dig_next_s[i] = (slot_r == SLW'(i)) && !lead_zero_s[i];
            end
        end
    end

    // Scan timer, slot rotation and registered display drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_timer_r <= '0;
            slot_r       <= '0;
            seg_r        <= 7'h00;
            dig_r        <= '0;
        end else begin
            scan_timer_r <= scan_timer_r + 1'b1;
            if (scan_timer_r == SCAN_WRAP) begin
                slot_r <= (slot_r == LAST_SLOT) ? '0 : slot_r + 1'b1;
            end
            seg_r <= seg_decode(cur_digit_s);
            dig_r <= dig_next_s;
        end
    end

    assign value = value_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign seg   = seg_r ^ {7{seg_inv}};
    assign dig   = dig_r ^ {DIGITS{dig_inv}};

endmodule

// File: tb/tb_dice_roller_multi.sv
// Scoreboard bench for dice_roller_multi (DIGITS=3, SETTLE_STEPS=4, SCAN_DIV=2).
// The driver runs an integer reference model and queues the expected outputs for each cycle.
// A negedge monitor pops the queue and compares it with the DUT.
module tb_dice_roller_multi;

    localparam int DIGITS    = 3;
    localparam int STEPS     = 4;
    localparam int SLOT_CLKS = 4;
    localparam int M_IDLE = 0, M_ROLL = 1, M_SETTLE = 2, M_SHOW = 3;

    logic        clk = 1'b0;
    logic        rst, roll, seg_inv, dig_inv;
    logic [2:0]  sel;
    logic [11:0] custom_max;
    logic [11:0] value;
    logic        busy, done;
    logic [6:0]  seg;
    logic [2:0]  dig;

    always #5 clk = ~clk;

    dice_roller_multi #(.DIGITS(3), .SETTLE_STEPS(4), .SCAN_DIV(2), .BLANK_WHILE_ROLL(1)) dut (
        .clk(clk), .rst(rst), .roll(roll), .sel(sel), .custom_max(custom_max),
        .seg_inv(seg_inv), .dig_inv(dig_inv), .value(value), .busy(busy),
        .done(done), .seg(seg), .dig(dig)
    );

    typedef struct {
        logic [11:0] value;
        logic        busy;
        logic        done;
        logic [6:0]  seg;
        logic [2:0]  dig;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_e;
    int   checks = 0;
    int   errors = 0;

    // reference model state (plain integers)
    int   m_val, m_max, m_mode, m_k, m_t, m_n;
    bit   m_busy, m_done;
    logic [6:0] m_seg;
    logic [2:0] m_dig;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int pow10(input int e);
        return (e == 0) ? 1 : ((e == 1) ? 10 : 100);
    endfunction

    function automatic logic [6:0] seg_of(input int d);
        logic [6:0] tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return tab[d];
    endfunction

    function automatic int die_max(input logic [2:0] s, input logic [11:0] c);
        int faces [7] = '{4, 6, 8, 10, 12, 20, 100};
        int d0, d1, d2;
        if (s != 3'd7) return faces[s];
        d0 = int'(c[3:0]);
        d1 = int'(c[7:4]);
        d2 = int'(c[11:8]);
        if (d0 > 9 || d1 > 9 || d2 > 9) return 1;
        if (d0 + d1 + d2 == 0) return 1;
        return d2 * 100 + d1 * 10 + d0;
    endfunction

    function automatic int next_val(input int v);
        return (v == 1) ? m_max : v - 1;
    endfunction

    // Advance the model by one clock, given the inputs applied to that clock.
    task automatic model_step(input bit r, input bit s_rst, input logic [2:0] s, input logic [11:0] c);
        int slot;
        if (s_rst) begin
            m_val = 1; m_max = 1; m_mode = M_IDLE; m_k = 0; m_t = 0; m_n = 0;
            m_busy = 1'b0; m_done = 1'b0; m_seg = 7'h00; m_dig = 3'b000;
            return;
        end
        slot  = (m_n / SLOT_CLKS) % DIGITS;
        m_seg = seg_of((m_val / pow10(slot)) % 10);
        if (m_busy) m_dig = 3'b000;
        else if (slot > 0 && m_val < pow10(slot)) m_dig = 3'b000;
        else m_dig = 3'(1 << slot);
        m_n++;
        m_done = 1'b0;
        if (m_mode == M_IDLE || m_mode == M_SHOW) begin
            if (r) begin m_max = die_max(s, c); m_val = m_max; m_mode = M_ROLL; end
        end else if (m_mode == M_ROLL) begin
            if (r) m_val = next_val(m_val);
            else begin m_mode = M_SETTLE; m_k = 0; m_t = 0; end
        end else begin
            if (r) m_mode = M_ROLL;
            else if (m_t == (1 << m_k) - 1) begin
                m_val = next_val(m_val); m_k++; m_t = 0;
                if (m_k == STEPS) begin m_mode = M_SHOW; m_done = 1'b1; end
            end else m_t++;
        end
        m_busy = (m_mode == M_ROLL || m_mode == M_SETTLE);
    endtask

    task automatic drive(input bit r, input bit s_rst, input logic [2:0] s, input logic [11:0] c,
                         input bit si, input bit di);
        exp_t e;
        rst = s_rst; roll = r; sel = s; custom_max = c; seg_inv = si; dig_inv = di;
        model_step(r, s_rst, s, c);
        @(posedge clk);
        e.value = to_bcd(m_val); e.busy = m_busy; e.done = m_done; e.seg = m_seg; e.dig = m_dig;
        exp_q.push_back(e);
        #1;
    endtask

    function automatic logic [11:0] rand_custom();
        if ($urandom_range(0, 1) == 0) return 12'($urandom);
        return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
    endfunction

    // roll/no-roll with random sel, custom and inversion (sel/custom only matter at roll start)
    task automatic rstep(input bit r);
        drive(r, 1'b0, 3'($urandom_range(0, 7)), rand_custom(), 1'($urandom), 1'($urandom));
    endtask

    task automatic roll_start(input logic [2:0] s, input logic [11:0] c, input int hold);
        drive(1'b1, 1'b0, s, c, 1'($urandom), 1'($urandom));
        for (int i = 1; i < hold; i++) rstep(1'b1);
    endtask

    // Monitor: compare every presented output cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur_e = exp_q.pop_front();
            chk("value", 32'(value), 32'(cur_e.value));
            chk("busy",  32'(busy),  32'(cur_e.busy));
            chk("done",  32'(done),  32'(cur_e.done));
            chk("seg",   32'(seg),   32'(cur_e.seg ^ {7{seg_inv}}));
            chk("dig",   32'(dig),   32'(cur_e.dig ^ {3{dig_inv}}));
        end
    end

    initial begin
        // reset, common-anode segments
        drive(1'b0, 1'b1, 3'd0, 12'h000, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 3'd0, 12'h000, 1'b1, 1'b0);
        chk("reset_value", 32'(value), 32'h001);
        chk("reset_seg", 32'(seg), 32'h7F);
        chk("reset_dig", 32'(dig), 32'h0);

        // D6, held 4 cycles
        roll_start(3'd1, 12'h000, 4);
        for (int i = 0; i < 20; i++) rstep(1'b0);
        chk("d6_final", 32'(value), 32'h005);
        chk("d6_busy", 32'(busy), 32'h0);

        // D100: wrap 001 -> 100 during settle, final 099 shown blanked on digit 2
        roll_start(3'd6, 12'h000, 98);
        for (int i = 0; i < 40; i++) rstep(1'b0);
        chk("d100_final", 32'(value), 32'h099);

        // re-roll in the middle of settle, no reload
        roll_start(3'd2, 12'h000, 3);
        for (int i = 0; i < 4; i++) rstep(1'b0);
        rstep(1'b1);
        rstep(1'b1);
        for (int i = 0; i < 20; i++) rstep(1'b0);
        chk("reroll_final", 32'(value), 32'h007);

        // invalid custom maximum falls back to 1
        roll_start(3'd7, 12'h0A5, 3);
        for (int i = 0; i < 20; i++) rstep(1'b0);
        chk("bad_custom", 32'(value), 32'h001);

        // settle onto 012 and let the scan run
        roll_start(3'd7, 12'h016, 1);
        for (int i = 0; i < 40; i++) rstep(1'b0);
        chk("scan_value", 32'(value), 32'h012);

        // random rolls, occasional mid-run reset
        for (int n = 0; n < 40; n++) begin
            roll_start(3'($urandom_range(0, 7)), rand_custom(), int'($urandom_range(1, 14)));
            if ($urandom_range(0, 9) == 0)
                drive(1'b0, 1'b1, 3'd0, 12'h000, 1'($urandom), 1'($urandom));
            for (int i = 0; i < int'($urandom_range(1, 24)); i++) rstep(1'b0);
        end

        rstep(1'b0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
